game_scheduler: RTL and testbench
=================================

// Module: game_scheduler
// PURPOSE
//   Sequences the scrolling datapath (horizon lines, obstacles, score) for one game session.
//   Converts the per-frame tick into single-cycle update strobes and ramps scroll speed with
//   saturation. Accumulates distance travelled and runs the start/crash/restart state machine,
//   issuing game_rst to downstream blocks on restart.
// PARAMETERS
//   SPEED_INIT      6144   initial speed, px/frame * SPEED_SCALE (1024); 6.0 px/frame
//   SPEED_MAX       13312  speed ceiling; 13.0 px/frame
//   ACCEL           1      speed increment applied per update strobe
//   RESTART_FRAMES  30     frame ticks after crash before a restart is accepted
// PORTS
//   clk          in   1    system clock
//   rst          in   1    synchronous, active-high reset
//   frame_tick   in   1    1-cycle pulse per video frame (vsync-derived)
//   start_btn    in   1    debounced jump/start button, level
//   crash        in   1    collision flag from detector, level or pulse
//   update       out  1    1-cycle strobe: datapath advances one frame
//   speed        out  15   current scroll speed, unsigned, scaled by 1024
//   start        out  1    1-cycle pulse when a run begins
//   game_rst     out  1    1-cycle pulse clearing datapath state on restart
//   running      out  1    high in RUNNING
//   crashed      out  1    high in CRASHED
//   distance     out  32   sum of speed over all updates this run, scaled by 1024
// BEHAVIOUR
//   Reset: state=IDLE; update=start=game_rst=0; speed=SPEED_INIT; distance=0;
//     cooldown=0; button history register cleared to 0.
//   Button: act only on rising edge of start_btn (registered previous value).
//     Holding the button does not retrigger.
//   IDLE: speed held at SPEED_INIT. Rising edge -> RUNNING; start=1 on that transition cycle.
//   RUNNING:
//     - frame_tick at cycle N -> update=1 at cycle N+1.
//     - speed stays stable through the cycle update is high. At the edge ending the strobe:
//       speed += ACCEL, saturating at SPEED_MAX; distance += pre-increment speed,
//       saturating at 2^32-1.
//     - Button edges ignored.
//   crash in RUNNING -> CRASHED next edge. crash has priority over a same-cycle frame_tick,
//     and that tick produces no update. A strobe already registered (high this cycle) still
//     completes. update never asserts outside RUNNING.
//   CRASHED: speed and distance frozen. cooldown counts frame_ticks, saturating at
//     RESTART_FRAMES. Button edge with cooldown<RESTART_FRAMES is ignored. Button edge with
//     cooldown==RESTART_FRAMES -> RESTART.
//   RESTART, 1 cycle: game_rst=1; speed:=SPEED_INIT; distance:=0; cooldown:=0.
//     Next edge -> RUNNING with start=1 in that cycle. frame_tick during RESTART is dropped.
//   crash is ignored in IDLE, CRASHED and RESTART.
//   start and game_rst are never high in the same cycle.
//   rst mid-operation returns to IDLE with reset values, regardless of state.
//   Outputs are registered; no combinational path from any input to any output.
// TESTING
//   1. rst then button edge -> start pulses once, running=1, speed=6144, no update until
//      first frame_tick.
//   2. 3 frame_ticks in RUNNING -> 3 update strobes, each 1 cycle after its tick;
//      speed=6147; distance=6144+6145+6146=18435.
//   3. Preload speed near max (SPEED_INIT=13311), 3 ticks -> speed sticks at 13312.
//   4. crash and frame_tick in same cycle -> no update, crashed=1, speed/distance unchanged
//      for 100 further ticks.
//   5. Button edge after 10 post-crash ticks -> ignored. Button edge after 30 ticks ->
//      game_rst 1 cycle, then start 1 cycle, speed=6144, distance=0.
//   6. Button held high across restart and rst asserted mid-RUNNING -> single start only;
//      rst gives IDLE, update=0, distance=0.

Source files
------------

// File: rtl/game_scheduler.sv
// game_scheduler
//   Sequences the scrolling datapath for one game session. Turns the per-frame
//   tick into single-cycle update strobes, ramps scroll speed (saturating),
//   accumulates distance travelled and runs the idle/run/crash/restart FSM.
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   frame_tick   1-cycle pulse per video frame
//   start_btn    debounced start/jump button (level)
//   crash        collision flag (level or pulse)
//   update       1-cycle strobe, datapath advances one frame
//   speed        scroll speed in px/frame * 1024 (15 bits)
//   start        1-cycle pulse as a run begins
//   game_rst     1-cycle pulse clearing datapath state on restart
//   running      high while running
//   crashed      high while crashed
//   distance     sum of speed over all updates this run (32 bits, saturating)
module game_scheduler #(
  parameter int unsigned SPEED_INIT     = 6144,
  parameter int unsigned SPEED_MAX      = 13312,
  parameter int unsigned ACCEL          = 1,
  parameter int unsigned RESTART_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        crash,
  output logic        update,
  output logic [14:0] speed,
  output logic        start,
  output logic        game_rst,
  output logic        running,
  output logic        crashed,
  output logic [31:0] distance
);

  localparam int unsigned CW = $clog2(RESTART_FRAMES + 2);
  localparam logic [14:0] L_SPEED_INIT = 15'(SPEED_INIT);
  localparam logic [15:0] L_SPEED_MAX  = 16'(SPEED_MAX);
  localparam logic [CW-1:0] L_RESTART  = CW'(RESTART_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUNNING,
    S_CRASHED,
    S_RESTART
  } state_t;

  state_t        r_state;
  logic          r_btn_prev;
  logic          r_update;
  logic          r_start;
  logic          r_game_rst;
  logic          r_running;
  logic          r_crashed;
  logic [14:0]   r_speed;
  logic [31:0]   r_distance;
  logic [CW-1:0] r_cooldown;

  logic          w_btn_rise;
  logic [15:0]   w_speed_inc;
  logic [14:0]   w_speed_next;
  logic [32:0]   w_dist_sum;
  logic [31:0]   w_dist_next;

  assign w_btn_rise   = start_btn & ~r_btn_prev;
  assign w_speed_inc  = {1'b0, r_speed} + 16'(ACCEL);
  assign w_speed_next = (w_speed_inc >= L_SPEED_MAX) ? L_SPEED_MAX[14:0] : w_speed_inc[14:0];
  assign w_dist_sum   = {1'b0, r_distance} + {18'd0, r_speed};
  assign w_dist_next  = w_dist_sum[32] ? '1 : w_dist_sum[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_btn_prev <= 1'b0;
      r_update   <= 1'b0;
      r_start    <= 1'b0;
      r_game_rst <= 1'b0;
      r_running  <= 1'b0;
      r_crashed  <= 1'b0;
      r_speed    <= L_SPEED_INIT;
      r_distance <= '0;
      r_cooldown <= '0;
    end else begin
      r_btn_prev <= start_btn;
      r_update   <= 1'b0;
      r_start    <= 1'b0;
      r_game_rst <= 1'b0;

      // The strobe's edge applies the advance even if this same edge moves
      // to CRASHED: a strobe already issued always completes.
      if (r_update) begin
        r_speed    <= w_speed_next;
        r_distance <= w_dist_next;
      end

      case (r_state)
        S_IDLE: begin
          r_speed <= L_SPEED_INIT;
          if (w_btn_rise) begin
            r_state   <= S_RUNNING;
            r_start   <= 1'b1;
            r_running <= 1'b1;
          end
        end
        S_RUNNING: begin
          // crash wins over a same-cycle tick; that tick is lost
          if (crash) begin
            r_state   <= S_CRASHED;
            r_running <= 1'b0;
            r_crashed <= 1'b1;
          end else if (frame_tick) begin
            r_update <= 1'b1;
          end
        end
        S_CRASHED: begin
          if (frame_tick && (r_cooldown < L_RESTART))
            r_cooldown <= r_cooldown + 1'b1;
          if (w_btn_rise && (r_cooldown == L_RESTART)) begin
            r_state    <= S_RESTART;
            r_crashed  <= 1'b0;
            r_game_rst <= 1'b1;
            r_speed    <= L_SPEED_INIT;
            r_distance <= '0;
            r_cooldown <= '0;
          end
        end
        S_RESTART: begin
          r_state   <= S_RUNNING;
          r_start   <= 1'b1;
          r_running <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign update   = r_update;
  assign speed    = r_speed;
  assign start    = r_start;
  assign game_rst = r_game_rst;
  assign running  = r_running;
  assign crashed  = r_crashed;
  assign distance = r_distance;

endmodule

// File: tb/tb_game_scheduler.sv
module tb_game_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick, start_btn, crash;
  logic        d_update, d_start, d_game_rst, d_running, d_crashed;
  logic [14:0] d_speed;
  logic [31:0] d_distance;

  // second instance preloaded near the speed ceiling
  logic        s_tick, s_btn;
  logic        s_update, s_start, s_game_rst, s_running, s_crashed;
  logic [14:0] s_speed;
  logic [31:0] s_distance;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_start = 0;
  int unsigned m_speed, m_dist;
  int unsigned q_speed[$];

  always #5 clk = ~clk;

  game_scheduler u_dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn), .crash(crash),
    .update(d_update), .speed(d_speed), .start(d_start), .game_rst(d_game_rst),
    .running(d_running), .crashed(d_crashed), .distance(d_distance)
  );

  game_scheduler #(.SPEED_INIT(13311)) u_dut_sat (
    .clk(clk), .rst(rst), .frame_tick(s_tick), .start_btn(s_btn), .crash(1'b0),
    .update(s_update), .speed(s_speed), .start(s_start), .game_rst(s_game_rst),
    .running(s_running), .crashed(s_crashed), .distance(s_distance)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the next queued pre-increment speed
  always @(negedge clk) begin
    if (!rst) begin
      if (d_start) n_start++;
      if (d_start && d_game_rst) check_val("start_grst_overlap", 1, 0);
      if (d_update) begin
        if (q_speed.size() == 0) check_val("unexpected_update", 1, 0);
        else check_val("update_speed", 32'(d_speed), q_speed.pop_front());
      end
    end
  end

  // Tick expected to produce a strobe: push expectation and advance the model
  task automatic tick_run();
    @(negedge clk) frame_tick = 1'b1;
    q_speed.push_back(m_speed);
    m_dist  = (m_dist + m_speed < m_dist) ? 32'hFFFF_FFFF : m_dist + m_speed;
    m_speed = (m_speed + 1 > 13312) ? 13312 : m_speed + 1;
    @(negedge clk) frame_tick = 1'b0;
    check_val("update_latency", 32'(d_update), 1);
    @(negedge clk);
    check_val("update_width", 32'(d_update), 0);
  endtask

  // Tick while crashed: no strobe, crash input pulsed too (must be ignored)
  task automatic tick_frozen();
    @(negedge clk) begin frame_tick = 1'b1; crash = 1'b1; end
    @(negedge clk) begin frame_tick = 1'b0; crash = 1'b0; end
  endtask

  task automatic press_ignored(input string tag);
    @(negedge clk) start_btn = 1'b1;
    @(negedge clk) start_btn = 1'b0;
    check_val({tag, "_grst"}, 32'(d_game_rst), 0);
    check_val({tag, "_crashed"}, 32'(d_crashed), 1);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; crash = 1'b0;
    s_tick = 1'b0; s_btn = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_running", 32'(d_running), 0);
    check_val("rst_crashed", 32'(d_crashed), 0);
    check_val("rst_update", 32'(d_update), 0);
    check_val("rst_speed", 32'(d_speed), 6144);
    check_val("rst_distance", d_distance, 0);
    rst = 1'b0;

    // 1: start on button edge, held button does not retrigger
    @(negedge clk) start_btn = 1'b1;
    @(negedge clk);
    check_val("start_pulse", 32'(d_start), 1);
    check_val("start_running", 32'(d_running), 1);
    check_val("start_speed", 32'(d_speed), 6144);
    @(negedge clk);
    check_val("start_width", 32'(d_start), 0);
    repeat (4) @(negedge clk);
    check_val("no_update_before_tick", 32'(d_update), 0);
    check_val("single_start", n_start, 1);
    start_btn = 1'b0;

    // 2: three ticks
    m_speed = 6144; m_dist = 0;
    repeat (3) tick_run();
    check_val("ramp_speed", 32'(d_speed), 6147);
    check_val("ramp_distance", d_distance, 18435);
    check_val("model_distance", d_distance, m_dist);

    // 4: crash with same-cycle tick
    @(negedge clk) begin frame_tick = 1'b1; crash = 1'b1; end
    @(negedge clk) begin frame_tick = 1'b0; crash = 1'b0; end
    check_val("crash_no_update", 32'(d_update), 0);
    check_val("crash_crashed", 32'(d_crashed), 1);
    check_val("crash_running", 32'(d_running), 0);

    // 5: cooldown boundary
    repeat (10) tick_frozen();
    press_ignored("press_cd10");
    repeat (19) tick_frozen();
    press_ignored("press_cd29");
    tick_frozen();
    check_val("frozen_speed", 32'(d_speed), 6147);
    check_val("frozen_distance", d_distance, 18435);

    // accepted edge at cooldown==30, button held high across the restart
    @(negedge clk) start_btn = 1'b1;
    @(negedge clk) frame_tick = 1'b1;
    check_val("restart_grst", 32'(d_game_rst), 1);
    check_val("restart_start", 32'(d_start), 0);
    check_val("restart_crashed", 32'(d_crashed), 0);
    @(negedge clk) frame_tick = 1'b0;
    check_val("rerun_start", 32'(d_start), 1);
    check_val("rerun_grst", 32'(d_game_rst), 0);
    check_val("rerun_running", 32'(d_running), 1);
    check_val("rerun_speed", 32'(d_speed), 6144);
    check_val("rerun_distance", d_distance, 0);
    repeat (3) @(negedge clk);
    check_val("restart_tick_dropped", 32'(d_update), 0);

    // 6: held button, more ticks, then rst mid-run
    m_speed = 6144; m_dist = 0;
    repeat (2) tick_run();
    check_val("rerun_ramp_speed", 32'(d_speed), m_speed);
    check_val("rerun_ramp_distance", d_distance, m_dist);
    check_val("restart_single_start", n_start, 2);
    start_btn = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_val("midrst_running", 32'(d_running), 0);
    check_val("midrst_update", 32'(d_update), 0);
    check_val("midrst_distance", d_distance, 0);
    check_val("midrst_speed", 32'(d_speed), 6144);

    // 3: saturation on the preloaded instance
    @(negedge clk) s_btn = 1'b1;
    @(negedge clk) s_btn = 1'b0;
    check_val("sat_start", 32'(s_start), 1);
    check_val("sat_speed0", 32'(s_speed), 13311);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) s_tick = 1'b1;
      @(negedge clk) s_tick = 1'b0;
      check_val("sat_update", 32'(s_update), 1);
      check_val("sat_pre_speed", 32'(s_speed), (i == 0) ? 13311 : 13312);
      @(negedge clk);
    end
    check_val("sat_speed", 32'(s_speed), 13312);
    check_val("sat_distance", s_distance, 39935);
    check_val("queue_drained", q_speed.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
